// File: rtl/rgb_pwm_pkg.sv
// Shared definitions for the rgb_pwm output stage.
//   DUTY_W     : width of duty, shadow and phase values
//   ch_idx_e   : channel index (red, green, blue)
//   GAMMA_LUT  : 256-entry perceptual gamma table, g(d) = (d*d + 128) >> 8,
//                present only when RGB_PWM_GAMMA_EN is defined
package rgb_pwm_pkg;

    localparam int unsigned DUTY_W = 8;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } ch_idx_e;

`ifdef RGB_PWM_GAMMA_EN
    typedef logic [255:0][DUTY_W-1:0] gamma_lut_t;

    function automatic gamma_lut_t build_gamma_lut();
        gamma_lut_t lut;
        for (int unsigned d = 0; d < 256; d++) begin
            lut[8'(d)] = DUTY_W'((d * d + 32'd128) >> 8);
        end
        return lut;
    endfunction

    localparam gamma_lut_t GAMMA_LUT = build_gamma_lut();
`endif

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: double-buffered duty (shadow register), optional gamma
// map, and registered compare output.
// Optional feature: RGB_PWM_GAMMA_EN maps duty through GAMMA_LUT before the
// shadow load.
// Ports:
//   clock, reset_n : system clock, asynchronous active-low reset
//   enable         : 0 forces the output low
//   load           : capture duty into the shadow at this edge
//   duty           : raw duty value in PWM ticks
//   phase_next     : phase value being loaded at this edge
//   pwm            : registered PWM output, active high
module pwm_channel
    import rgb_pwm_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              load,
    input  logic [DUTY_W-1:0] duty,
    input  logic [DUTY_W-1:0] phase_next,
    output logic              pwm
);

    logic [DUTY_W-1:0] duty_mapped;
    logic [DUTY_W-1:0] shadow_q, shadow_d;
    logic              pwm_q, pwm_d;

`ifdef RGB_PWM_GAMMA_EN
    assign duty_mapped = GAMMA_LUT[duty];
`else
    assign duty_mapped = duty;
`endif

    // Compare against the values that will be held after this edge, so the
    // output lines up with phase without an extra cycle of latency.
    always_comb begin
        shadow_d = load ? duty_mapped : shadow_q;
        pwm_d    = enable && (phase_next < shadow_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/rgb_pwm.sv
// Three-channel PWM output stage for the RGB indicator LEDs. A shared
// prescaler and phase counter drive three pwm_channel instances; duty values
// take effect only at period boundaries.
// Optional feature: RGB_PWM_GAMMA_EN (gamma map on duty before shadow load).
// Parameters: PRESCALE clocks per tick (>=1), PERIOD ticks per period (2..256).
// Ports:
//   clock, reset_n         : system clock, asynchronous active-low reset
//   enable                 : 1 = run, 0 = outputs off and counters held at 0
//   duty_r, duty_g, duty_b : duty in PWM ticks high per period
//   pwm_r, pwm_g, pwm_b    : registered PWM outputs, active high
//   period_start           : one-clock pulse on the first clock of each period
module rgb_pwm
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE = 200,
    parameter int unsigned PERIOD   = 250
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DUTY_W-1:0] duty_r,
    input  logic [DUTY_W-1:0] duty_g,
    input  logic [DUTY_W-1:0] duty_b,
    output logic              pwm_r,
    output logic              pwm_g,
    output logic              pwm_b,
    output logic              period_start
);

    localparam int unsigned       PRE_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST   = PRE_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0] PHASE_LAST = DUTY_W'(PERIOD - 1);

    logic [PRE_W-1:0]  prescaler_q, prescaler_d;
    logic [DUTY_W-1:0] phase_q, phase_d;
    logic              enable_q;
    logic              period_start_q, period_start_d;
    logic              tick, wrap, start, load;
    logic [2:0]        pwm_vec;

    always_comb begin
        tick  = enable && (prescaler_q == PRE_LAST);
        wrap  = tick && (phase_q == PHASE_LAST);
        // First enabled clock after disable/reset is treated as a wrap so the
        // period restarts cleanly with fresh duties.
        start = enable && (!enable_q || wrap);
        // Shadows track duty continuously while disabled.
        load  = start || !enable;

        prescaler_d    = prescaler_q;
        phase_d        = phase_q;
        period_start_d = start;

        if (!enable || start) begin
            prescaler_d = '0;
            phase_d     = '0;
        end else begin
            prescaler_d = tick ? '0 : prescaler_q + 1'b1;
            if (tick) begin
                phase_d = phase_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescaler_q    <= '0;
            phase_q        <= '0;
            enable_q       <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            prescaler_q    <= prescaler_d;
            phase_q        <= phase_d;
            enable_q       <= enable;
            period_start_q <= period_start_d;
        end
    end

    pwm_channel u_ch_r (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .load       (load),
        .duty       (duty_r),
        .phase_next (phase_d),
        .pwm        (pwm_vec[CH_R])
    );

    pwm_channel u_ch_g (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .load       (load),
        .duty       (duty_g),
        .phase_next (phase_d),
        .pwm        (pwm_vec[CH_G])
    );

    pwm_channel u_ch_b (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .load       (load),
        .duty       (duty_b),
        .phase_next (phase_d),
        .pwm        (pwm_vec[CH_B])
    );

    assign pwm_r        = pwm_vec[CH_R];
    assign pwm_g        = pwm_vec[CH_G];
    assign pwm_b        = pwm_vec[CH_B];
    assign period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm.sv
// Self-checking bench for rgb_pwm. Instance 0 uses PRESCALE=2/PERIOD=10,
// instance 1 uses PRESCALE=1/PERIOD=250. A clock-count reference model
// (clocks since period start, duty captured at period start) predicts outputs.
module tb_rgb_pwm;

    logic       clk;
    logic       rst_n;
    logic       en [2];
    logic [7:0] dr [2];
    logic [7:0] dg [2];
    logic [7:0] db [2];
    logic       pr [2];
    logic       pg [2];
    logic       pb [2];
    logic       ps [2];

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    int m_t   [2];
    bit m_run [2];
    int m_sh  [2][3];
    bit m_pwm [2][3];
    bit m_ps  [2];

    rgb_pwm #(.PRESCALE(2), .PERIOD(10)) dut0 (
        .clock        (clk),
        .reset_n      (rst_n),
        .enable       (en[0]),
        .duty_r       (dr[0]),
        .duty_g       (dg[0]),
        .duty_b       (db[0]),
        .pwm_r        (pr[0]),
        .pwm_g        (pg[0]),
        .pwm_b        (pb[0]),
        .period_start (ps[0])
    );

    rgb_pwm #(.PRESCALE(1), .PERIOD(250)) dut1 (
        .clock        (clk),
        .reset_n      (rst_n),
        .enable       (en[1]),
        .duty_r       (dr[1]),
        .duty_g       (dg[1]),
        .duty_b       (db[1]),
        .pwm_r        (pr[1]),
        .pwm_g        (pg[1]),
        .pwm_b        (pb[1]),
        .period_start (ps[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pre_of(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int per_of(int i);
        return (i == 0) ? 10 : 250;
    endfunction

    function automatic int gmap(int d);
`ifdef RGB_PWM_GAMMA_EN
        return (d * d + 128) / 256;
`else
        return d;
`endif
    endfunction

    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    // Clocks high per period for a given duty.
    function automatic int hi_per(int i, int d);
        return pre_of(i) * imin(gmap(d), per_of(i));
    endfunction

    function automatic logic [3:0] exp_vec(int i);
        return {m_ps[i], m_pwm[i][2], m_pwm[i][1], m_pwm[i][0]};
    endfunction

    function automatic logic [3:0] obs_vec(int i);
        return {ps[i], pb[i], pg[i], pr[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_t[i]   = 0;
            m_run[i] = 1'b0;
            m_ps[i]  = 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_sh[i][c]  = 0;
                m_pwm[i][c] = 1'b0;
            end
        end
    endtask

    task automatic model_step(int i);
        int d [3];
        int len;
        d   = '{int'(dr[i]), int'(dg[i]), int'(db[i])};
        len = pre_of(i) * per_of(i);
        if (!en[i]) begin
            m_run[i] = 1'b0;
            m_ps[i]  = 1'b0;
            for (int c = 0; c < 3; c++) begin
                m_sh[i][c]  = gmap(d[c]);
                m_pwm[i][c] = 1'b0;
            end
        end else begin
            if (!m_run[i] || m_t[i] == len - 1) begin
                m_t[i]   = 0;
                m_run[i] = 1'b1;
                m_ps[i]  = 1'b1;
                for (int c = 0; c < 3; c++) m_sh[i][c] = gmap(d[c]);
            end else begin
                m_t[i]++;
                m_ps[i] = 1'b0;
            end
            for (int c = 0; c < 3; c++) m_pwm[i][c] = (m_t[i] / pre_of(i)) < m_sh[i][c];
        end
    endtask

    // Advance one clock; model follows the inputs seen at the edge.
    task automatic cyc();
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 2; i++) model_step(i);
        end
        #1;
    endtask

    task automatic test_reset();
        #3;
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (obs_vec(i) !== 4'b0000)
                $display("FAIL reset_state dut%0d: got %b expected 0000", i, obs_vec(i));
            else n_pass++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            cyc();
            n_total++;
            if (obs_vec(0) !== exp_vec(0))
                $display("FAIL reset_idle: got %b expected %b", obs_vec(0), exp_vec(0));
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        int ps_cnt = 0, r_hi = 0, g_hi = 0, b_hi = 0;
        en[0] = 1'b1; dr[0] = 8'd3; dg[0] = 8'd0; db[0] = 8'd10;
        for (int k = 0; k < 60; k++) begin
            cyc();
            ps_cnt += int'(ps[0]); r_hi += int'(pr[0]);
            g_hi += int'(pg[0]); b_hi += int'(pb[0]);
            n_total++;
            if (obs_vec(0) !== exp_vec(0))
                $display("FAIL basic_cyc%0d: got %b expected %b", k, obs_vec(0), exp_vec(0));
            else n_pass++;
        end
        n_total++;
        if (ps_cnt !== 3) $display("FAIL basic_ps_count: got %0d expected 3", ps_cnt);
        else n_pass++;
        n_total++;
        if (r_hi !== 3 * hi_per(0, 3))
            $display("FAIL basic_r_high: got %0d expected %0d", r_hi, 3 * hi_per(0, 3));
        else n_pass++;
        n_total++;
        if (g_hi !== 3 * hi_per(0, 0))
            $display("FAIL basic_g_high: got %0d expected %0d", g_hi, 3 * hi_per(0, 0));
        else n_pass++;
        n_total++;
        if (b_hi !== 3 * hi_per(0, 10))
            $display("FAIL basic_b_high: got %0d expected %0d", b_hi, 3 * hi_per(0, 10));
        else n_pass++;
    endtask

    task automatic test_duty_change();
        int hi_a = 0, hi_b = 0;
        for (int k = 1; k <= 40; k++) begin
            cyc();
            if (k <= 20) hi_a += int'(pr[0]);
            else hi_b += int'(pr[0]);
            n_total++;
            if (obs_vec(0) !== exp_vec(0))
                $display("FAIL duty_cyc%0d: got %b expected %b", k, obs_vec(0), exp_vec(0));
            else n_pass++;
            if (k == 9) dr[0] = 8'd7;  // phase 4 of the current period
        end
        n_total++;
        if (hi_a !== hi_per(0, 3))
            $display("FAIL duty_old_period: got %0d expected %0d", hi_a, hi_per(0, 3));
        else n_pass++;
        n_total++;
        if (hi_b !== hi_per(0, 7))
            $display("FAIL duty_new_period: got %0d expected %0d", hi_b, hi_per(0, 7));
        else n_pass++;
    endtask

    task automatic test_enable();
        int ps_cnt = 0, r_hi = 0;
        for (int k = 1; k <= 11; k++) cyc();
        en[0] = 1'b0;  // phase 5
        for (int k = 0; k < 7; k++) begin
            cyc();
            n_total++;
            if (obs_vec(0) !== 4'b0000)
                $display("FAIL disable_low%0d: got %b expected 0000", k, obs_vec(0));
            else n_pass++;
        end
        dr[0] = 8'd2;
        en[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (k == 0) begin
                n_total++;
                if ({ps[0], pr[0]} !== {1'b1, gmap(2) > 0})
                    $display("FAIL reenable_first: got %b expected %b",
                             {ps[0], pr[0]}, {1'b1, gmap(2) > 0});
                else n_pass++;
            end
            ps_cnt += int'(ps[0]); r_hi += int'(pr[0]);
            n_total++;
            if (obs_vec(0) !== exp_vec(0))
                $display("FAIL reenable_cyc%0d: got %b expected %b", k, obs_vec(0), exp_vec(0));
            else n_pass++;
        end
        n_total++;
        if (ps_cnt !== 1) $display("FAIL reenable_ps_count: got %0d expected 1", ps_cnt);
        else n_pass++;
        n_total++;
        if (r_hi !== hi_per(0, 2))
            $display("FAIL reenable_r_high: got %0d expected %0d", r_hi, hi_per(0, 2));
        else n_pass++;
    endtask

    task automatic test_async_reset();
        dr[0] = 8'd7;
        for (int k = 1; k <= 13; k++) begin
            cyc();
            n_total++;
            if (obs_vec(0) !== exp_vec(0))
                $display("FAIL pre_reset_cyc%0d: got %b expected %b", k, obs_vec(0), exp_vec(0));
            else n_pass++;
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if (obs_vec(i) !== 4'b0000)
                $display("FAIL async_reset dut%0d: got %b expected 0000", i, obs_vec(i));
            else n_pass++;
        end
        #1 rst_n = 1'b1;
        cyc();
        n_total++;
        if (ps[0] !== 1'b1) $display("FAIL post_reset_ps: got %b expected 1", ps[0]);
        else n_pass++;
        n_total++;
        if (obs_vec(0) !== exp_vec(0))
            $display("FAIL post_reset_vec: got %b expected %b", obs_vec(0), exp_vec(0));
        else n_pass++;
    endtask

    task automatic test_wide();
        int r_lo = 0, g_hi = 0, b_hi = 0, b_d;
        b_d = int'($urandom_range(0, 255));
        en[1] = 1'b1; dr[1] = 8'd249; dg[1] = 8'd255; db[1] = 8'(b_d);
        for (int k = 0; k < 500; k++) begin
            cyc();
            r_lo += int'(!pr[1]); g_hi += int'(pg[1]); b_hi += int'(pb[1]);
            n_total++;
            if (obs_vec(1) !== exp_vec(1))
                $display("FAIL wide_cyc%0d: got %b expected %b", k, obs_vec(1), exp_vec(1));
            else n_pass++;
        end
        n_total++;
        if (r_lo !== 500 - 2 * hi_per(1, 249))
            $display("FAIL wide_r_low: got %0d expected %0d", r_lo, 500 - 2 * hi_per(1, 249));
        else n_pass++;
        n_total++;
        if (g_hi !== 2 * hi_per(1, 255))
            $display("FAIL wide_g_high: got %0d expected %0d", g_hi, 2 * hi_per(1, 255));
        else n_pass++;
        n_total++;
        if (b_hi !== 2 * hi_per(1, b_d))
            $display("FAIL wide_b_high: got %0d expected %0d", b_hi, 2 * hi_per(1, b_d));
        else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 800; k++) begin
            int i;
            i = int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0: dr[i] = 8'($urandom_range(0, 255));
                    1: dg[i] = 8'($urandom_range(0, 255));
                    default: db[i] = 8'($urandom_range(0, 255));
                endcase
            end
            if ($urandom_range(0, 59) == 0) en[i] = ~en[i];
            cyc();
            for (int j = 0; j < 2; j++) begin
                n_total++;
                if (obs_vec(j) !== exp_vec(j))
                    $display("FAIL random_cyc%0d dut%0d: got %b expected %b",
                             k, j, obs_vec(j), exp_vec(j));
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            en[i] = 1'b0; dr[i] = '0; dg[i] = '0; db[i] = '0;
        end
        model_reset();
        test_reset();
        test_basic();
        test_duty_change();
        test_enable();
        test_async_reset();
        test_wide();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
